// File: rtl/sram_readback_sequencer.sv
// sram_readback_sequencer: drains SRAM addresses 0..N-1 onto a valid/ready byte stream.
// Define READBACK_CRC_EN to build the running CRC-16/CCITT; otherwise CRC is tied to 16'hFFFF.
module sram_readback_sequencer #(
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 8,
  parameter int SRAM_RD_LAT = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [ADDR_WIDTH-1:0] LIMIT,
  input  logic                  LIMIT_FULL,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic                  SRAM_OE_N,
  input  logic [DATA_WIDTH-1:0] SRAM_DATA,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DOUT_VALID,
  input  logic                  DOUT_READY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [15:0]           CRC
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    PRESENT,
    FINISH
  } state_t;

  localparam logic [3:0] LAT_LAST = 4'(SRAM_RD_LAT - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t state;
  state_t nxt;

  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] last;
  logic [3:0]            lat_cnt;

  logic load;
  logic n_zero;
  logic capture;
  logic advance;
  logic acc_byte;
  logic kill;

  // next-state and per-cycle strobes
  always_comb begin
    nxt      = state;
    load     = 1'b0;
    capture  = 1'b0;
    advance  = 1'b0;
    n_zero   = (LIMIT == '0) && !LIMIT_FULL;
    acc_byte = (state == PRESENT) && DOUT_VALID
             && DOUT_READY && !ABORT;
    kill     = ABORT && (state != IDLE);
    unique case (state)
      IDLE: begin
        if (START && !ABORT) begin
          load = 1'b1;
          nxt  = n_zero ? FINISH : READ;
        end
      end
      READ: begin
        if (ABORT) begin
          nxt = IDLE;
        end else if (lat_cnt == LAT_LAST) begin
          capture = 1'b1;
          nxt     = PRESENT;
        end
      end
      PRESENT: begin
        if (ABORT) begin
          nxt = IDLE;
        end else if (acc_byte) begin
          if (ptr == last) begin
            nxt = FINISH;
          end else begin
            advance = 1'b1;
            nxt     = READ;
          end
        end
      end
      FINISH: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // state, pointer, SRAM control and stream registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state      <= IDLE;
      ptr        <= '0;
      last       <= '0;
      lat_cnt    <= '0;
      SRAM_ADDR  <= '0;
      SRAM_OE_N  <= 1'b1;
      DOUT       <= '0;
      DOUT_VALID <= 1'b0;
    end else begin
      state <= nxt;
      if (load) begin
        ptr       <= '0;
        last      <= LIMIT_FULL ? '1 : LIMIT - ONE;
        lat_cnt   <= '0;
        SRAM_ADDR <= '0;
        SRAM_OE_N <= n_zero;
      end
      if (state == READ && !capture) begin
        lat_cnt <= lat_cnt + 4'd1;
      end
      if (capture) begin
        DOUT       <= SRAM_DATA;
        DOUT_VALID <= 1'b1;
        SRAM_OE_N  <= 1'b1;
      end
      if (acc_byte) begin
        DOUT_VALID <= 1'b0;
      end
      if (advance) begin
        ptr       <= ptr + ONE;
        SRAM_ADDR <= ptr + ONE;
        SRAM_OE_N <= 1'b0;
        lat_cnt   <= '0;
      end
      if (kill) begin
        DOUT_VALID <= 1'b0;
        SRAM_OE_N  <= 1'b1;
      end
    end
  end

  assign BUSY = (state == READ) || (state == PRESENT);
  assign DONE = (state == FINISH);

`ifdef READBACK_CRC_EN
  logic [15:0] crc_q;

  function automatic logic [15:0] crc_next(
    input logic [15:0]           c,
    input logic [DATA_WIDTH-1:0] d
  );
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  // CRC over accepted bytes, restarted by each accepted START
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      crc_q <= 16'hFFFF;
    end else if (load) begin
      crc_q <= 16'hFFFF;
    end else if (acc_byte) begin
      crc_q <= crc_next(crc_q, DOUT);
    end
  end

  assign CRC = crc_q;
`else
  assign CRC = 16'hFFFF;
`endif

endmodule

// File: tb/tb_sram_readback_sequencer.sv
// tb_sram_readback_sequencer: scoreboard bench for the SRAM readback sequencer.
// Small SRAM model with read latency; expected bytes queued at START, popped on accept.
module tb_sram_readback_sequencer;

  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic [AW-1:0] LIMIT = '0;
  logic          LIMIT_FULL = 1'b0;
  logic [AW-1:0] SRAM_ADDR;
  logic          SRAM_OE_N;
  logic [DW-1:0] SRAM_DATA;
  logic [DW-1:0] DOUT;
  logic          DOUT_VALID;
  logic          DOUT_READY = 1'b0;
  logic          BUSY;
  logic          DONE;
  logic [15:0]   CRC;

  always #5 CLK = ~CLK;

  sram_readback_sequencer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .SRAM_RD_LAT(LAT)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .START     (START),
    .ABORT     (ABORT),
    .LIMIT     (LIMIT),
    .LIMIT_FULL(LIMIT_FULL),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_OE_N (SRAM_OE_N),
    .SRAM_DATA (SRAM_DATA),
    .DOUT      (DOUT),
    .DOUT_VALID(DOUT_VALID),
    .DOUT_READY(DOUT_READY),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .CRC       (CRC)
  );

  logic [7:0] mem [16];
  int         age = 0;

  always @(posedge CLK)
    age <= SRAM_OE_N ? 0 : (age < 15 ? age + 1 : age);

  assign SRAM_DATA = (!SRAM_OE_N && age >= LAT - 1)
                   ? mem[SRAM_ADDR] : 8'hEE;

  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          accepted = 0;
  int          mode = 0;
  int          held = 0;
  logic [7:0]  q [$];
  logic [7:0]  exp_b;
  logic [15:0] crc_m = 16'hFFFF;
  bit          oe_low_seen = 0;
  logic        prst = 0, pv = 0, pr = 0, pa = 0;
  logic [7:0]  pd = '0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(logic [15:0] c, logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] crc_exp();
`ifdef READBACK_CRC_EN
    return crc_m;
`else
    return 16'hFFFF;
`endif
  endfunction

  // stream monitor: scoreboard pops, hold-under-backpressure, DONE count
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (DONE) done_cnt++;
      if (!SRAM_OE_N) oe_low_seen = 1;
      if (prst && pv && !pr && !pa) begin
        check("hold_valid", 32'(DOUT_VALID), 1);
        check("hold_data", 32'(DOUT), 32'(pd));
      end
      if (DOUT_VALID) check("oe_in_present", 32'(SRAM_OE_N), 1);
      if (DOUT_VALID && DOUT_READY && !ABORT) begin
        accepted++;
        if (q.size() == 0) begin
          check("extra_byte", 1, 0);
        end else begin
          exp_b = q.pop_front();
          check("dout", 32'(DOUT), 32'(exp_b));
          crc_m = crc_upd(crc_m, exp_b);
        end
      end
    end
    prst = RESET_N;
    pv   = DOUT_VALID;
    pr   = DOUT_READY;
    pa   = ABORT;
    pd   = DOUT;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_vals(string tag);
    check({tag, "_addr"}, 32'(SRAM_ADDR), 0);
    check({tag, "_oe_n"}, 32'(SRAM_OE_N), 1);
    check({tag, "_dout"}, 32'(DOUT), 0);
    check({tag, "_valid"}, 32'(DOUT_VALID), 0);
    check({tag, "_busy"}, 32'(BUSY), 0);
    check({tag, "_done"}, 32'(DONE), 0);
    check({tag, "_crc"}, 32'(CRC), 32'hFFFF);
  endtask

  task automatic start_rb(int n, bit full, logic [AW-1:0] lim);
    tick();
    START      = 1;
    LIMIT      = lim;
    LIMIT_FULL = full;
    crc_m      = 16'hFFFF;
    accepted   = 0;
    held       = 0;
    for (int i = 0; i < n; i++) q.push_back(mem[i]);
    tick();
    START      = 0;
    LIMIT      = ~lim;
    LIMIT_FULL = !full;
  endtask

  task automatic drive_ready();
    case (mode)
      1: begin
        if (accepted == 2 && held < 10) begin
          DOUT_READY = 0;
          if (DOUT_VALID) held++;
          if (held == 5) begin
            START = 1;
            LIMIT = 1;
          end else begin
            START = 0;
          end
        end else begin
          DOUT_READY = 1;
          START      = 0;
        end
      end
      2: DOUT_READY = 1'($urandom_range(0, 1));
      default: DOUT_READY = 1;
    endcase
  endtask

  task automatic wait_done(string tag, int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      tick();
      drive_ready();
      k++;
    end
    if (done_cnt == d0) check({tag, "_timeout"}, 0, 1);
    START      = 0;
    DOUT_READY = 1;
    repeat (3) tick();
    check({tag, "_done_once"}, 32'(done_cnt - d0), 1);
    check({tag, "_all_bytes"}, 32'(q.size()), 0);
    check({tag, "_busy"}, 32'(BUSY), 0);
    check({tag, "_crc"}, 32'(CRC), 32'(crc_exp()));
    q.delete();
  endtask

  initial begin
    int lat;
    int d0;
    int k;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);

    RESET_N = 0;
    repeat (3) tick();
    reset_vals("reset");
    RESET_N    = 1;
    DOUT_READY = 1;
    tick();

    mem[0] = 8'hA5; mem[1] = 8'h5A; mem[2] = 8'h00; mem[3] = 8'hFF;
    mode = 0;
    start_rb(4, 0, 4'd4);
    lat = 1;
    while (!DOUT_VALID && lat < 20) begin
      tick();
      lat++;
    end
    check("first_valid_latency", 32'(lat), 32'(LAT + 1));
    wait_done("basic", 100);

    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mode = 1;
    start_rb(4, 0, 4'd4);
    wait_done("backpressure", 200);
    mode = 0;

    oe_low_seen = 0;
    d0 = done_cnt;
    start_rb(0, 0, 4'd0);
    lat = 1;
    while (!DONE && lat < 10) begin
      tick();
      lat++;
    end
    check("zero_done_latency_ok", 32'(lat <= 2), 1);
    repeat (3) tick();
    check("zero_done_once", 32'(done_cnt - d0), 1);
    check("zero_no_oe", 32'(oe_low_seen), 0);
    check("zero_busy", 32'(BUSY), 0);

    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 37 + 11);
    start_rb(16, 1, 4'd5);
    wait_done("full", 300);

    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h80 + i);
    d0 = done_cnt;
    start_rb(8, 0, 4'd8);
    k = 0;
    while (accepted < 2 && k < 100) begin
      tick();
      k++;
    end
    check("abort_reached_two", 32'(accepted), 2);
    ABORT = 1;
    tick();
    ABORT = 0;
    check("abort_busy", 32'(BUSY), 0);
    check("abort_valid", 32'(DOUT_VALID), 0);
    check("abort_oe_n", 32'(SRAM_OE_N), 1);
    repeat (5) tick();
    check("abort_no_done", 32'(done_cnt - d0), 0);
    q.delete();
    start_rb(3, 0, 4'd3);
    wait_done("after_abort", 100);

    for (int i = 0; i < 9; i++) mem[i] = 8'(8'h31 + i);
    mode = 2;
    start_rb(9, 0, 4'd9);
    wait_done("crc9", 400);
    mode = 0;
`ifdef READBACK_CRC_EN
    check("crc_123456789", 32'(CRC), 32'h29B1);
`else
    check("crc_tied", 32'(CRC), 32'hFFFF);
`endif

    DOUT_READY = 0;
    start_rb(4, 0, 4'd4);
    k = 0;
    while (!DOUT_VALID && k < 20) begin
      tick();
      k++;
    end
    check("rst_reached_present", 32'(DOUT_VALID), 1);
    d0 = done_cnt;
    RESET_N = 0;
    tick();
    reset_vals("mid_reset");
    RESET_N    = 1;
    DOUT_READY = 1;
    repeat (4) tick();
    check("mid_reset_no_done", 32'(done_cnt - d0), 0);
    check("mid_reset_idle", 32'(BUSY), 0);
    q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
